// File: rtl/msx_reset_seq.sv
// Reset sequencer for the MSX core: debounces the config-changed flag and merges
// OSD reset, ROM download and SDRAM readiness into one minimum-width core reset.
module msx_reset_seq #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int HOLD_CYCLES     = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reload,
    input  logic       user_reset,
    input  logic       ioctl_download,
    input  logic       sdram_ready,
    output logic       core_reset,
    output logic       reload_pending,
    output logic [7:0] reset_count
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              core_reset_q, core_reset_d;
    logic              reload_pending_q, reload_pending_d;
    logic [7:0]        reset_count_q, reset_count_d;
    logic              force_any;
    logic              count_inc;

    assign force_any = user_reset | ioctl_download | ~sdram_ready;

    // State register; the global reset lands in HOLD so the core starts held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_HOLD;
            db_cnt_q         <= '0;
            hold_cnt_q       <= '0;
            core_reset_q     <= 1'b1;
            reload_pending_q <= 1'b0;
            reset_count_q    <= 8'd0;
        end else begin
            state_q          <= state_d;
            db_cnt_q         <= db_cnt_d;
            hold_cnt_q       <= hold_cnt_d;
            core_reset_q     <= core_reset_d;
            reload_pending_q <= reload_pending_d;
            reset_count_q    <= reset_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        count_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (force_any) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    count_inc  = 1'b1;
                end else if (reload) begin
                    state_d  = ST_DEBOUNCE;
                    db_cnt_d = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (force_any) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    count_inc  = 1'b1;
                end else if (!reload) begin
                    // User stepped back to the snapshotted config: no reset needed.
                    state_d = ST_IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    count_inc  = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                // reload is ignored here; the config block re-snapshots under reset.
                if (force_any) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        core_reset_d     = (state_d == ST_HOLD);
        reload_pending_d = (state_q == ST_DEBOUNCE);
        reset_count_d    = reset_count_q;
        if (count_inc && (reset_count_q != 8'hFF)) begin
            reset_count_d = reset_count_q + 8'd1;
        end
    end

    assign core_reset     = core_reset_q;
    assign reload_pending = reload_pending_q;
    assign reset_count    = reset_count_q;

endmodule

// File: tb/tb_msx_reset_seq.sv
// Directed bench for msx_reset_seq with DEBOUNCE_CYCLES=4, HOLD_CYCLES=3: a
// cycle-level behavioural model checked every cycle, plus literal timing pins.
module tb_msx_reset_seq;

    localparam int DB   = 4;
    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reload = 1'b0;
    logic       user_reset = 1'b0;
    logic       ioctl_download = 1'b0;
    logic       sdram_ready = 1'b1;
    logic       core_reset;
    logic       reload_pending;
    logic [7:0] reset_count;

    int errors = 0;
    int checks = 0;

    msx_reset_seq #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .reload        (reload),
        .user_reset    (user_reset),
        .ioctl_download(ioctl_download),
        .sdram_ready   (sdram_ready),
        .core_reset    (core_reset),
        .reload_pending(reload_pending),
        .reset_count   (reset_count)
    );

    always #5 clk = ~clk;

    // Model: reset is "held" with a countdown of cycles left; debounce is a run
    // length of consecutive reload samples (-1 when not debouncing).
    bit model_valid = 1'b0;
    bit m_rst = 1'b1;
    bit m_pend = 1'b0;
    int m_hold_left = HOLD;
    int m_db_run = -1;
    int m_count = 0;

    task start_hold();
        m_rst       = 1'b1;
        m_hold_left = HOLD;
        m_db_run    = -1;
        m_count     = (m_count < 255) ? m_count + 1 : 255;
    endtask

    always @(posedge clk) begin
        bit f;
        bit was_db;
        f = user_reset | ioctl_download | ~sdram_ready;
        if (reset) begin
            m_rst       = 1'b1;
            m_hold_left = HOLD;
            m_db_run    = -1;
            m_pend      = 1'b0;
            m_count     = 0;
            model_valid = 1'b1;
        end else begin
            was_db = (m_db_run >= 0);
            if (m_rst) begin
                if (f) m_hold_left = HOLD;
                else begin
                    m_hold_left = m_hold_left - 1;
                    if (m_hold_left == 0) m_rst = 1'b0;
                end
            end else if (f) begin
                start_hold();
            end else if (was_db) begin
                if (!reload) m_db_run = -1;
                else if (m_db_run == DB) start_hold();
                else m_db_run = m_db_run + 1;
            end else if (reload) begin
                m_db_run = 1;
            end
            m_pend = was_db;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (core_reset !== m_rst) begin
                errors++;
                $display("FAIL model core_reset t=%0t dut=%b exp=%b", $time, core_reset, m_rst);
            end
            checks++;
            if (reload_pending !== m_pend) begin
                errors++;
                $display("FAIL model reload_pending t=%0t dut=%b exp=%b", $time, reload_pending, m_pend);
            end
            checks++;
            if (reset_count !== 8'(m_count)) begin
                errors++;
                $display("FAIL model reset_count t=%0t dut=%0d exp=%0d", $time, reset_count, m_count);
            end
        end
    end

    task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t dut=%0d exp=%0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Power-on: reset sampled on two edges, then HOLD runs 3 more edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_lit("por_core_reset", {7'd0, core_reset}, 8'd1);
        check_lit("por_count", reset_count, 8'd0);
        check_lit("por_pending", {7'd0, reload_pending}, 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_lit("por_release", {7'd0, core_reset}, (i < 2) ? 8'd1 : 8'd0);
        end
        check_lit("por_count_after", reset_count, 8'd0);

        // Debounced reload from edge E0.
        reload = 1'b1;
        step(1);
        check_lit("db_pend_e0", {7'd0, reload_pending}, 8'd0);
        step(3);
        check_lit("db_pend_e3", {7'd0, reload_pending}, 8'd1);
        check_lit("db_core_e3", {7'd0, core_reset}, 8'd0);
        step(1);
        check_lit("db_core_e4", {7'd0, core_reset}, 8'd1);
        check_lit("db_pend_e4", {7'd0, reload_pending}, 8'd1);
        check_lit("db_count", reset_count, 8'd1);
        reload = 1'b0;
        step(1);
        check_lit("db_pend_e5", {7'd0, reload_pending}, 8'd0);
        step(1);
        check_lit("db_core_e6", {7'd0, core_reset}, 8'd1);
        step(1);
        check_lit("db_core_e7", {7'd0, core_reset}, 8'd0);

        // Glitch abort: 2 high, 1 low, 5 high.
        reload = 1'b1;
        step(2);
        reload = 1'b0;
        step(1);
        check_lit("gl_core_g2", {7'd0, core_reset}, 8'd0);
        check_lit("gl_pend_g2", {7'd0, reload_pending}, 8'd1);
        reload = 1'b1;
        step(1);
        check_lit("gl_pend_g3", {7'd0, reload_pending}, 8'd0);
        step(3);
        check_lit("gl_core_g6", {7'd0, core_reset}, 8'd0);
        step(1);
        check_lit("gl_core_g7", {7'd0, core_reset}, 8'd1);
        check_lit("gl_count", reset_count, 8'd2);
        reload = 1'b0;
        step(3);
        check_lit("gl_exit", {7'd0, core_reset}, 8'd0);

        // Hold extension: ioctl_download high for 10 samples.
        ioctl_download = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_lit("hx_core_dl", {7'd0, core_reset}, 8'd1);
        end
        ioctl_download = 1'b0;
        step(2);
        check_lit("hx_core_h11", {7'd0, core_reset}, 8'd1);
        step(1);
        check_lit("hx_core_h12", {7'd0, core_reset}, 8'd0);
        check_lit("hx_count", reset_count, 8'd3);

        // Simultaneous user_reset and reload, then SDRAM not ready.
        user_reset = 1'b1;
        reload     = 1'b1;
        step(1);
        check_lit("sim_core", {7'd0, core_reset}, 8'd1);
        check_lit("sim_count", reset_count, 8'd4);
        user_reset  = 1'b0;
        reload      = 1'b0;
        sdram_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_lit("sim_sdram_hold", {7'd0, core_reset}, 8'd1);
            check_lit("sim_no_pend", {7'd0, reload_pending}, 8'd0);
        end
        sdram_ready = 1'b1;
        step(3);
        check_lit("sim_exit", {7'd0, core_reset}, 8'd0);
        check_lit("sim_count_after", reset_count, 8'd4);

        // Saturation: 300 one-cycle user_reset pulses, each fully served.
        for (int i = 0; i < 300; i++) begin
            user_reset = 1'b1;
            step(1);
            user_reset = 1'b0;
            step(3);
        end
        check_lit("sat_count", reset_count, 8'd255);
        check_lit("sat_idle", {7'd0, core_reset}, 8'd0);

        // Global reset in the middle of a debounce.
        reload = 1'b1;
        step(2);
        check_lit("mid_pend", {7'd0, reload_pending}, 8'd1);
        reset = 1'b1;
        step(1);
        check_lit("mid_core", {7'd0, core_reset}, 8'd1);
        check_lit("mid_count", reset_count, 8'd0);
        check_lit("mid_pend_clr", {7'd0, reload_pending}, 8'd0);
        reset  = 1'b0;
        reload = 1'b0;
        step(3);
        check_lit("mid_exit", {7'd0, core_reset}, 8'd0);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msx_reset_seq.md
# msx_reset_seq

Reset sequencer that sits directly downstream of the MSX configuration block. It consumes the config block's `reload` flag (live OSD config differs from the config snapshotted at the last core reset), debounces it while the user is still stepping through menu options, and issues a clean, minimum-width `core_reset`. The same `core_reset` drives the config block's own reset, which re-snapshots the config and clears `reload`. It also merges OSD reset, HPS download activity and SDRAM readiness into that single core reset.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1024: cycles `reload` must stay continuously high before a reset is issued; ≥1.
- `HOLD_CYCLES`, default 64: minimum `core_reset` width in cycles, counted after all blocking conditions clear; ≥1.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high; global/power-on reset.
- `reload`  in  1  config-changed flag from the config block.
- `user_reset`  in  1  OSD/button reset request, level.
- `ioctl_download`  in  1  HPS ROM download in progress, level.
- `sdram_ready`  in  1  SDRAM init complete, level.
- `core_reset`  out  1  registered reset to the MSX core and config block.
- `reload_pending`  out  1  high while in DEBOUNCE (OSD status).
- `reset_count`  out  8  saturating count of resets issued since `reset`.

## Operation
- Define `force = user_reset | ioctl_download | ~sdram_ready`.
- States: IDLE, DEBOUNCE, HOLD. Counters: `db_cnt` (width `$clog2(DEBOUNCE_CYCLES)`, min 1) and `hold_cnt` (width `$clog2(HOLD_CYCLES)`, min 1).
- `reset` (any state, overrides everything): state=HOLD, `hold_cnt`=0, `db_cnt`=0, `core_reset`=1, `reset_count`=0.
- IDLE (`core_reset`=0):
  - `force` → HOLD, `hold_cnt`=0, `reset_count`++.
  - else `reload` → DEBOUNCE, `db_cnt`=0.
  - else stay.
- DEBOUNCE (`core_reset`=0), priority order:
  1. `force` → HOLD, `reset_count`++.
  2. `~reload` → IDLE, no reset (user reverted the config).
  3. `db_cnt == DEBOUNCE_CYCLES-1` → HOLD, `hold_cnt`=0, `reset_count`++.
  4. else `db_cnt`++.
- HOLD (`core_reset`=1):
  - `force` → `hold_cnt`=0, stay.
  - else if `hold_cnt == HOLD_CYCLES-1` → IDLE.
  - else `hold_cnt`++.
  - `reload` is ignored in HOLD. The config block re-snapshots while reset is high, so `reload` is 0 on exit.
- `reset_count` saturates at 255. Power-on/global reset entry is not counted.
- `reload_pending` = (state == DEBOUNCE), registered.

## Timing
- All outputs are registered and change only on `clk` rising edges.
- Reset values: `core_reset`=1, `reload_pending`=0, `reset_count`=0.
- Debounce latency: `reload` first sampled high in IDLE at edge E0 → `core_reset` high after edge E0+DEBOUNCE_CYCLES. `reload_pending` is high from E0+1 through E0+DEBOUNCE_CYCLES.
- `reload` low for one sampled cycle during DEBOUNCE aborts the debounce. The next high restarts the count from 0.
- Hold width: with `force`=0 throughout, `core_reset` is high for exactly HOLD_CYCLES cycles. Any cycle with `force`=1 restarts the count, so deassertion happens HOLD_CYCLES cycles after the last `force`=1 sample.
- `force` and `reload` rising on the same edge in IDLE → HOLD (force wins). No DEBOUNCE is entered.
- `reset` asserted mid-DEBOUNCE or mid-HOLD → HOLD with `hold_cnt`=0 on the next edge. `reset_count` clears.

## Test plan
Bench settings for all scenarios: DEBOUNCE_CYCLES=4, HOLD_CYCLES=3.

- Power-on: `reset` high 2 cycles, `sdram_ready`=1 → `core_reset`=1 through reset, then exactly 3 more cycles, then 0. `reset_count`=0.
- Debounced reload: `reload` high from edge E0 → `reload_pending` high for edges E0+1..E0+4. `core_reset` high for cycles E0+4..E0+6. `reset_count`=1. Model `reload` dropping one cycle after `core_reset` rises.
- Glitch abort: `reload` high 2 cycles, low 1 cycle, then high 5 → the first burst produces no reset. `core_reset` rises 4 cycles after the second rise.
- Hold extension: in HOLD, `ioctl_download` high 10 cycles → `core_reset` stays high, deasserting 3 cycles after `ioctl_download` falls. `reset_count` increments once.
- Simultaneous events: `user_reset` and `reload` rise together in IDLE → immediate HOLD, `reload_pending` never 1. `sdram_ready`=0 holds `core_reset` indefinitely.
- Saturation: 300 `user_reset` pulses → `reset_count`=255. `reset` mid-DEBOUNCE → `core_reset`=1 next edge, `reset_count`=0.
